// File: rtl/dmem_arb_pkg.sv
// Shared encodings and default widths for the dmem arbiter slice.
package dmem_arb_pkg;
  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 4;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_FORCE_D = 1'b1
  } state_e;
endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating loader wait counter; thr flags the last refusal before forcing.
module dmem_arb_wait_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             thr
);
  localparam logic [CNT_W-1:0] MAXV = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] THRV = CNT_W'(MAX_WAIT - 1);

  always_ff @(posedge clock) begin
    if (!reset)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && cnt != MAXV) cnt <= cnt + 1'b1;
  end

  assign thr = (cnt == THRV);
endmodule

// File: rtl/dmem_arbiter.sv
// Processor / loader arbiter for the single-port dmem syncram.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);
  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_thr;

  dmem_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clock (clock),
    .reset (reset),
    .inc   (d_req & ~d_gnt),
    .clr   (d_gnt | ~d_req),
    .cnt   (wait_cnt),
    .thr   (wait_thr)
  );

  // grants are held low while reset is asserted
  always_comb begin
    p_gnt   = 1'b0;
    d_gnt   = 1'b0;
    state_d = state_q;
    if (reset) begin
      case (state_q)
        ST_NORMAL: begin
          p_gnt = p_req;
          d_gnt = d_req & ~p_req;
          if (wait_thr && d_req && !d_gnt) state_d = ST_FORCE_D;
        end
        ST_FORCE_D: begin
          d_gnt = d_req;
          p_gnt = p_req & ~d_req;
          if (d_gnt || !d_req) state_d = ST_NORMAL;
        end
        default: state_d = ST_NORMAL;
      endcase
    end
  end

  always_comb begin
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    owner_d      = OWN_NONE;
    if (p_gnt) begin
      address_dmem = p_addr;
      data         = p_wdata;
      wren         = p_we;
      if (!p_we) owner_d = OWN_P;
    end else if (d_gnt) begin
      address_dmem = d_addr;
      data         = d_wdata;
      wren         = d_we;
      if (!d_we) owner_d = OWN_D;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_NORMAL;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign p_stall  = p_req & ~p_gnt;
  assign p_rvalid = (owner_q == OWN_P);
  assign d_rvalid = (owner_q == OWN_D);
  assign p_rdata  = p_rvalid ? q_dmem : '0;
  assign d_rdata  = d_rvalid ? q_dmem : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: dmem syncram model plus a refusal-count arbitration model.
module tb_dmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          p_req, p_we, d_req, d_we;
  logic [AW-1:0] p_addr, d_addr;
  logic [DW-1:0] p_wdata, d_wdata;
  logic          p_gnt, p_stall, p_rvalid, d_gnt, d_rvalid, wren;
  logic [DW-1:0] p_rdata, d_rdata, data, q_dmem;
  logic [AW-1:0] address_dmem;

  logic [DW-1:0] mem     [4096];
  logic [DW-1:0] ref_mem [4096];

  int checks = 0;
  int errors = 0;
  int refused = 0;
  bit e_pv = 0, e_dv = 0;
  logic [DW-1:0] e_prd = '0, e_drd = '0;
  bit last_pg, last_dg;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (wren) mem[address_dmem] <= data;
    q_dmem <= mem[address_dmem];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: grants follow "loader wins once refused MW times in a row".
  task automatic cycle();
    bit            eg_p, eg_d, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    #1;
    eg_d = reset && d_req && (!p_req || refused >= MW);
    eg_p = reset && p_req && !eg_d;
    ea = eg_p ? p_addr : eg_d ? d_addr : '0;
    ed = eg_p ? p_wdata : eg_d ? d_wdata : '0;
    ew = (eg_p && p_we) || (eg_d && d_we);
    chk("p_gnt", p_gnt, eg_p);
    chk("d_gnt", d_gnt, eg_d);
    chk("p_stall", p_stall, p_req && !eg_p);
    chk("wren", wren, ew);
    chk("addr", address_dmem, ea);
    chk("wdata", data, ed);
    last_pg = eg_p;
    last_dg = eg_d;
    e_pv = eg_p && !p_we;
    e_dv = eg_d && !d_we;
    e_prd = e_pv ? ref_mem[ea] : '0;
    e_drd = e_dv ? ref_mem[ea] : '0;
    if (ew) ref_mem[ea] = ed;
    if (!reset) refused = 0;
    else if (d_req && !eg_d) refused = (refused + 1 > MW) ? MW : refused + 1;
    else refused = 0;
    @(posedge clock);
    #1;
    chk("p_rvalid", p_rvalid, e_pv);
    chk("p_rdata", p_rdata, e_prd);
    chk("d_rvalid", d_rvalid, e_dv);
    chk("d_rdata", d_rdata, e_drd);
  endtask

  task automatic idle();
    p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    idle();
    reset = 0;
    p_req = 1; d_req = 1;
    cycle(); cycle();
    reset = 1;
    cycle();
    chk("first_after_reset", {p_gnt, d_gnt}, 2'b10);
    idle();

    p_req = 1; p_we = 1; p_addr = 12'h010; p_wdata = 32'hDEADBEEF;
    cycle();
    p_we = 0;
    cycle();
    chk("rd_back", p_rdata, 32'hDEADBEEF);
    idle();
    cycle();

    p_req = 1; d_req = 1; d_addr = 12'h010; p_addr = 12'h020;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_dg) break;
      n++;
    end
    chk("d_wait", n, MW);
    d_req = 0;
    cycle(); cycle();
    idle();

    for (int i = 0; i < 8; i++) begin
      d_req = 1; d_we = 1; d_addr = AW'(i); d_wdata = DW'(i + 1);
      cycle();
    end
    for (int i = 0; i < 8; i++) begin
      d_we = 0; d_addr = AW'(i);
      cycle();
      chk("ld_stream", d_rdata, DW'(i + 1));
    end
    idle();
    cycle();

    p_req = 1; p_addr = 12'h003; cycle();
    p_req = 0; d_req = 1; d_addr = 12'h010; cycle();
    d_req = 0; p_req = 1; p_addr = 12'h005; cycle();
    idle();
    cycle();

    p_req = 1; p_addr = 12'h002; cycle();
    idle(); reset = 0; cycle();
    reset = 1; cycle();
    chk("rst_rvalid", {p_rvalid, d_rvalid}, 2'b00);

    for (int c = 0; c < 400; c++) begin
      if (!p_req || last_pg) begin
        p_req = ($urandom_range(0, 3) != 0);
        p_we = $urandom_range(0, 1);
        p_addr = AW'($urandom_range(0, 15));
        p_wdata = $urandom;
      end
      if (!d_req || last_dg) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_we = $urandom_range(0, 1);
        d_addr = AW'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      reset = ($urandom_range(0, 49) != 0);
      cycle();
    end
    reset = 1;
    idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
